// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: refill FSM encoding and address-field width helpers
// shared by the instruction cache files.
package instr_cache_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_MEM_READ, ST_UPDATE} state_e;

    localparam int BYTE_OFF_W = 2;

    function automatic int word_off_w(input int words_per_block);
        return $clog2(words_per_block);
    endfunction

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int words_per_block, input int num_lines);
        return addr_w - BYTE_OFF_W - $clog2(words_per_block) - $clog2(num_lines);
    endfunction

    function automatic int block_addr_w(input int addr_w, input int word_w, input int words_per_block);
        return addr_w - $clog2(word_w / 8 * words_per_block);
    endfunction

endpackage

// File: rtl/instr_cache_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones maximum instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache with whole-block refill,
// flush support and saturating hit/miss counters.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_LINES       = 8,
    parameter int CNT_W           = 16
) (
    input  logic                                                 CLK,
    input  logic                                                 RESET,
    input  logic                                                 READ,
    input  logic [ADDR_W-1:0]                                    ADDRESS,
    input  logic                                                 FLUSH,
    output logic [WORD_W-1:0]                                    INSTRUCTION,
    output logic                                                 BUSYWAIT,
    output logic                                                 MEM_READ,
    output logic [block_addr_w(ADDR_W, WORD_W, WORDS_PER_BLOCK)-1:0] MEM_ADDRESS,
    input  logic [WORD_W*WORDS_PER_BLOCK-1:0]                    MEM_READDATA,
    input  logic                                                 MEM_BUSYWAIT,
    output logic [CNT_W-1:0]                                     HIT_COUNT,
    output logic [CNT_W-1:0]                                     MISS_COUNT
);
    localparam int OFF_W  = word_off_w(WORDS_PER_BLOCK);
    localparam int IDX_W  = index_w(NUM_LINES);
    localparam int TAG_W  = tag_w(ADDR_W, WORDS_PER_BLOCK, NUM_LINES);
    localparam int BLK_W  = block_addr_w(ADDR_W, WORD_W, WORDS_PER_BLOCK);
    localparam int LINE_W = WORD_W * WORDS_PER_BLOCK;

    state_e               state_q, state_d;
    logic [BLK_W-1:0]     blk_q, blk_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    logic [OFF_W-1:0] woff;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             idle, hit, hit_inc, miss_inc, unused_bits;

    assign woff        = ADDRESS[BYTE_OFF_W +: OFF_W];
    assign idx         = ADDRESS[BYTE_OFF_W+OFF_W +: IDX_W];
    assign tag         = ADDRESS[ADDR_W-1 -: TAG_W];
    assign unused_bits = ^ADDRESS[BYTE_OFF_W-1:0];
    assign idle        = state_q == ST_IDLE;
    assign hit         = valid_q[idx] && tag_q[idx] == tag;
    assign hit_inc     = idle && READ && hit;
    assign miss_inc    = idle && READ && !hit;
    assign INSTRUCTION = data_q[idx][woff*WORD_W +: WORD_W];
    assign BUSYWAIT    = !idle || miss_inc;
    assign MEM_READ    = state_q == ST_MEM_READ;
    assign MEM_ADDRESS = blk_q;

    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q || (!idle && FLUSH);
        case (state_q)
            ST_IDLE: if (miss_inc) begin
                state_d = ST_MEM_READ;
                blk_d   = ADDRESS[ADDR_W-1 -: BLK_W];
            end
            ST_MEM_READ: if (!MEM_BUSYWAIT) state_d = ST_UPDATE;
            ST_UPDATE: begin
                state_d                  = ST_IDLE;
                valid_d[blk_q[IDX_W-1:0]] = 1'b1;
                flush_pend_d             = 1'b0;
                // a flush seen during the refill also kills the line just filled
                if (flush_pend_q || FLUSH) valid_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (idle && FLUSH) valid_d = '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_IDLE;
            blk_q        <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (state_q == ST_UPDATE) begin
            tag_q[blk_q[IDX_W-1:0]]  <= blk_q[BLK_W-1 -: TAG_W];
            data_q[blk_q[IDX_W-1:0]] <= MEM_READDATA;
        end
    end

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk(CLK), .rst_n(RESET), .inc_i(hit_inc), .cnt_o(HIT_COUNT)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk(CLK), .rst_n(RESET), .inc_i(miss_inc), .cnt_o(MISS_COUNT)
    );
endmodule
